// File: rtl/common.sv
// Shared decode types for the branch/control stage: instruction classes,
// major opcodes, branch funct3 codes and the control bundle.
package common;

   typedef enum logic [2:0] {
      OP_R = 3'd0,
      OP_I = 3'd1,
      OP_S = 3'd2,
      OP_B = 3'd3,
      OP_U = 3'd4,
      OP_J = 3'd5
   } instruction_op_type;

   localparam logic [6:0] OPC_LOAD    = 7'b0000011;
   localparam logic [6:0] OPC_LOAD_FP = 7'b0000111;
   localparam logic [6:0] OPC_OP_IMM  = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
   localparam logic [6:0] OPC_STORE   = 7'b0100011;
   localparam logic [6:0] OPC_OP      = 7'b0110011;
   localparam logic [6:0] OPC_LUI     = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
   localparam logic [6:0] OPC_JALR    = 7'b1100111;
   localparam logic [6:0] OPC_JAL     = 7'b1101111;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef struct packed {
      logic mem_write;
      logic mem2reg;
      logic reg_write;
      logic alu_src;
      logic is_branch;
      logic auipc;
      logic is_jump;
   } ctrl_bundle_t;

endpackage

// File: rtl/branch_bht.sv
// 2-bit saturating branch history table; only built when BRANCH_CTRL_BHT_EN
// is defined. Lookup is combinational and sees the pre-update counter.
`ifdef BRANCH_CTRL_BHT_EN
module branch_bht #(
   parameter int BHT_DEPTH = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [$clog2(BHT_DEPTH)-1:0] lookup_idx,
   output logic                         lookup_taken,
   input  logic                         train_en,
   input  logic [$clog2(BHT_DEPTH)-1:0] train_idx,
   input  logic                         train_taken
);

   logic [1:0] cnt [BHT_DEPTH];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < BHT_DEPTH; i++) cnt[i] <= 2'b01;
      end else if (train_en) begin
         if (train_taken && cnt[train_idx] != 2'b11)
            cnt[train_idx] <= cnt[train_idx] + 2'b01;
         else if (!train_taken && cnt[train_idx] != 2'b00)
            cnt[train_idx] <= cnt[train_idx] - 2'b01;
      end
   end

   assign lookup_taken = cnt[lookup_idx][1];

endmodule
`endif

// File: rtl/branch_ctrl_stage.sv
// Decode-to-execute control and branch resolution stage with a single output
// register. The history table is present only when BRANCH_CTRL_BHT_EN is defined.
module branch_ctrl_stage
   import common::*;
#(
   parameter int XLEN      = 32,
   parameter int BHT_DEPTH = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [XLEN-1:0]    in_pc,
   input  logic [6:0]         in_opcode,
   input  instruction_op_type in_optype,
   input  logic [2:0]         in_funct3,
   input  logic [XLEN-1:0]    in_rs1_data,
   input  logic [XLEN-1:0]    in_rs2_data,
   input  logic [XLEN-1:0]    in_imm,
   input  logic               in_pred_taken,
   input  logic               flush,
   output logic               out_valid,
   input  logic               out_ready,
   output ctrl_bundle_t       out_ctrl,
   output logic               out_branch_taken,
   output logic               out_mispredict,
   output logic [XLEN-1:0]    out_target,
   input  logic [XLEN-1:0]    lookup_pc,
   output logic               lookup_taken
);

   localparam int BHT_IDX_W = $clog2(BHT_DEPTH);

   logic         accept;
   logic         cond_taken;
   logic         is_jalr;
   logic         taken_d;
   logic         mispredict_d;
   ctrl_bundle_t ctrl_d;
   logic [XLEN-1:0] pc_rel_sum;
   logic [XLEN-1:0] jalr_sum;
   logic [XLEN-1:0] target_d;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready && !flush;

   always_comb begin
      cond_taken = 1'b0;
      case (in_funct3)
         F3_BEQ:  cond_taken = (in_rs1_data == in_rs2_data);
         F3_BNE:  cond_taken = (in_rs1_data != in_rs2_data);
         F3_BLT:  cond_taken = ($signed(in_rs1_data) <  $signed(in_rs2_data));
         F3_BGE:  cond_taken = ($signed(in_rs1_data) >= $signed(in_rs2_data));
         F3_BLTU: cond_taken = (in_rs1_data <  in_rs2_data);
         F3_BGEU: cond_taken = (in_rs1_data >= in_rs2_data);
         default: cond_taken = 1'b0;
      endcase
   end

   always_comb begin
      ctrl_d  = '0;
      taken_d = 1'b0;
      is_jalr = 1'b0;
      case (in_optype)
         OP_R: ctrl_d.reg_write = 1'b1;
         OP_I: begin
            ctrl_d.reg_write = 1'b1;
            ctrl_d.alu_src   = 1'b1;
            ctrl_d.mem2reg   = (in_opcode == OPC_LOAD) || (in_opcode == OPC_LOAD_FP);
            if (in_opcode == OPC_JALR) begin
               is_jalr        = 1'b1;
               ctrl_d.is_jump = 1'b1;
               taken_d        = 1'b1;
            end
         end
         OP_S: begin
            ctrl_d.alu_src   = 1'b1;
            ctrl_d.mem_write = 1'b1;
         end
         OP_B: begin
            ctrl_d.is_branch = 1'b1;
            taken_d          = cond_taken;
         end
         OP_U: begin
            ctrl_d.reg_write = 1'b1;
            ctrl_d.alu_src   = 1'b1;
            ctrl_d.auipc     = (in_opcode == OPC_AUIPC);
         end
         OP_J: begin
            ctrl_d.is_jump   = 1'b1;
            ctrl_d.reg_write = 1'b1;
            taken_d          = 1'b1;
         end
         default: ctrl_d = '0;
      endcase
   end

   // Fall-through target doubles as the correction when a predicted-taken branch is not taken.
   assign pc_rel_sum   = in_pc + in_imm;
   assign jalr_sum     = in_rs1_data + in_imm;
   assign target_d     = !taken_d ? in_pc + XLEN'(4)
                       : is_jalr  ? {jalr_sum[XLEN-1:1], 1'b0}
                       :            pc_rel_sum;
   assign mispredict_d = (ctrl_d.is_branch || ctrl_d.is_jump) && (taken_d != in_pred_taken);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid        <= 1'b0;
         out_ctrl         <= '0;
         out_branch_taken <= 1'b0;
         out_mispredict   <= 1'b0;
         out_target       <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid        <= 1'b1;
         out_ctrl         <= ctrl_d;
         out_branch_taken <= taken_d;
         out_mispredict   <= mispredict_d;
         out_target       <= target_d;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef BRANCH_CTRL_BHT_EN
   logic unused_lookup_bits;
   assign unused_lookup_bits = ^{lookup_pc[XLEN-1:BHT_IDX_W+2], lookup_pc[1:0]};

   branch_bht #(
      .BHT_DEPTH (BHT_DEPTH)
   ) u_bht (
      .clk          (clk),
      .rst_n        (rst_n),
      .lookup_idx   (lookup_pc[BHT_IDX_W+1:2]),
      .lookup_taken (lookup_taken),
      .train_en     (accept && (in_optype == OP_B)),
      .train_idx    (in_pc[BHT_IDX_W+1:2]),
      .train_taken  (taken_d)
   );
`else
   logic unused_lookup_pc;
   assign unused_lookup_pc = ^lookup_pc;
   assign lookup_taken     = 1'b0;
`endif

endmodule

// File: tb/tb_branch_ctrl_stage.sv
// Scoreboard bench for branch_ctrl_stage; BHT expectations follow BRANCH_CTRL_BHT_EN.
module tb_branch_ctrl_stage;
   import common::*;

   localparam int XLEN      = 32;
   localparam int BHT_DEPTH = 16;
   localparam int IDX_W     = $clog2(BHT_DEPTH);
`ifdef BRANCH_CTRL_BHT_EN
   localparam bit BHT_ON = 1'b1;
`else
   localparam bit BHT_ON = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               rst_n = 1'b0;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic [XLEN-1:0]    in_pc = '0;
   logic [6:0]         in_opcode = '0;
   instruction_op_type in_optype = OP_R;
   logic [2:0]         in_funct3 = '0;
   logic [XLEN-1:0]    in_rs1_data = '0;
   logic [XLEN-1:0]    in_rs2_data = '0;
   logic [XLEN-1:0]    in_imm = '0;
   logic               in_pred_taken = 1'b0;
   logic               flush = 1'b0;
   logic               out_valid;
   logic               out_ready = 1'b1;
   ctrl_bundle_t       out_ctrl;
   logic               out_branch_taken;
   logic               out_mispredict;
   logic [XLEN-1:0]    out_target;
   logic [XLEN-1:0]    lookup_pc = '0;
   logic               lookup_taken;

   branch_ctrl_stage #(.XLEN(XLEN), .BHT_DEPTH(BHT_DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_opcode(in_opcode), .in_optype(in_optype),
      .in_funct3(in_funct3), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
      .in_imm(in_imm), .in_pred_taken(in_pred_taken), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
      .out_branch_taken(out_branch_taken), .out_mispredict(out_mispredict),
      .out_target(out_target), .lookup_pc(lookup_pc), .lookup_taken(lookup_taken)
   );

   typedef struct packed {
      ctrl_bundle_t    ctrl;
      logic            taken;
      logic            mis;
      logic [XLEN-1:0] target;
   } exp_t;

   exp_t       sb[$];
   exp_t       obs;
   logic [1:0] bht_m [BHT_DEPTH];
   logic       model_ov = 1'b0;
   int         checks = 0;
   int         errors = 0;

   assign obs = {out_ctrl, out_branch_taken, out_mispredict, out_target};

   function automatic exp_t model();
      exp_t e;
      logic jalr;
      e    = '0;
      jalr = 1'b0;
      case (in_optype)
         OP_R: e.ctrl.reg_write = 1'b1;
         OP_I: begin
            e.ctrl.reg_write = 1'b1;
            e.ctrl.alu_src   = 1'b1;
            if (in_opcode == 7'b0000011 || in_opcode == 7'b0000111) e.ctrl.mem2reg = 1'b1;
            if (in_opcode == 7'b1100111) begin
               jalr = 1'b1; e.ctrl.is_jump = 1'b1; e.taken = 1'b1;
            end
         end
         OP_S: begin e.ctrl.alu_src = 1'b1; e.ctrl.mem_write = 1'b1; end
         OP_B: begin
            e.ctrl.is_branch = 1'b1;
            case (in_funct3)
               3'd0: e.taken = (in_rs1_data == in_rs2_data);
               3'd1: e.taken = (in_rs1_data != in_rs2_data);
               3'd4: e.taken = (int'(in_rs1_data) <  int'(in_rs2_data));
               3'd5: e.taken = (int'(in_rs1_data) >= int'(in_rs2_data));
               3'd6: e.taken = ({1'b0, in_rs1_data} <  {1'b0, in_rs2_data});
               3'd7: e.taken = ({1'b0, in_rs1_data} >= {1'b0, in_rs2_data});
               default: e.taken = 1'b0;
            endcase
         end
         OP_U: begin
            e.ctrl.reg_write = 1'b1; e.ctrl.alu_src = 1'b1;
            e.ctrl.auipc = (in_opcode == 7'b0010111);
         end
         OP_J: begin e.ctrl.is_jump = 1'b1; e.ctrl.reg_write = 1'b1; e.taken = 1'b1; end
         default: e = '0;
      endcase
      if (!e.taken)  e.target = in_pc + 32'd4;
      else if (jalr) e.target = (in_rs1_data + in_imm) & ~32'd1;
      else           e.target = in_pc + in_imm;
      e.mis = (e.ctrl.is_branch || e.ctrl.is_jump) && (e.taken != in_pred_taken);
      return e;
   endfunction

   function automatic logic lookup_m(input logic [XLEN-1:0] pc);
      logic [IDX_W-1:0] idx;
      idx = pc[IDX_W+1:2];
      return BHT_ON ? bht_m[idx][1] : 1'b0;
   endfunction

   task automatic drive(input logic [6:0] op, input instruction_op_type ty, input logic [2:0] f3,
                        input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input logic pred);
      in_valid = 1'b1; in_opcode = op; in_optype = ty; in_funct3 = f3; in_pc = pc;
      in_rs1_data = a; in_rs2_data = b; in_imm = imm; in_pred_taken = pred;
   endtask

   // Advances one clock, updating the reference model with the values presented at the edge.
   task automatic cycle();
      logic acc;
      exp_t e;
      logic [IDX_W-1:0] idx;
      acc = rst_n && in_valid && (!model_ov || out_ready) && !flush;
      if (!rst_n) begin
         model_ov = 1'b0;
         sb.delete();
         for (int i = 0; i < BHT_DEPTH; i++) bht_m[i] = 2'b01;
      end else if (flush) begin
         model_ov = 1'b0;
         sb.delete();
      end else begin
         if (model_ov && out_ready && sb.size() > 0) void'(sb.pop_front());
         if (acc) begin
            e = model();
            sb.push_back(e);
            model_ov = 1'b1;
            if (in_optype == OP_B) begin
               idx = in_pc[IDX_W+1:2];
               if (e.taken && bht_m[idx] != 2'b11) bht_m[idx] = bht_m[idx] + 2'b01;
               else if (!e.taken && bht_m[idx] != 2'b00) bht_m[idx] = bht_m[idx] - 2'b01;
            end
         end else if (out_ready) begin
            model_ov = 1'b0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      cycle(); cycle();
      rst_n = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++; if (obs !== '0) begin errors++; $display("FAIL reset_payload: got %h expected 0", obs); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      for (int i = 0; i < BHT_DEPTH; i++) begin
         lookup_pc = 32'(i * 4);
         #1;
         checks++;
         if (lookup_taken !== 1'b0) begin
            errors++; $display("FAIL reset_lookup[%0d]: got %b expected 0", i, lookup_taken);
         end
      end
      cycle();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_out_valid: got %b expected 0", out_valid); end
   endtask

   typedef struct packed { logic [2:0] f3; logic [31:0] a; logic [31:0] b; logic [31:0] imm; } bcase_t;

   task automatic test_branch_compare();
      bcase_t bc [10];
      bc[0] = '{3'd4, 32'hFFFF_FFFF, 32'd1, 32'h40};
      bc[1] = '{3'd6, 32'hFFFF_FFFF, 32'd1, 32'h40};
      bc[2] = '{3'd0, 32'd5, 32'd5, 32'hFFFF_FFF0};
      bc[3] = '{3'd0, 32'd5, 32'd6, 32'h10};
      bc[4] = '{3'd1, 32'd5, 32'd6, 32'h10};
      bc[5] = '{3'd5, 32'd1, 32'hFFFF_FFFF, 32'h20};
      bc[6] = '{3'd7, 32'd1, 32'hFFFF_FFFF, 32'h20};
      bc[7] = '{3'd4, 32'd1, 32'd1, 32'h8};
      bc[8] = '{3'd2, 32'd5, 32'd5, 32'h8};
      bc[9] = '{3'd3, 32'd5, 32'd5, 32'h8};
      for (int i = 0; i < 10; i++) begin
         drive(7'b1100011, OP_B, bc[i].f3, 32'h200 + 32'(i * 4), bc[i].a, bc[i].b, bc[i].imm,
               (i >= 2) ? 1'(i % 2) : 1'b0);
         cycle();
         checks++;
         if (out_valid !== 1'b1 || sb.size() == 0 || obs !== sb[0]) begin
            errors++; $display("FAIL branch[%0d]: got v=%b %h expected %h", i, out_valid, obs, (sb.size() > 0) ? sb[0] : '0);
         end
         if (i == 0) begin
            checks++;
            if (out_branch_taken !== 1'b1 || out_mispredict !== 1'b1 || out_target !== 32'h240) begin
               errors++; $display("FAIL blt_signed: got t=%b m=%b tgt=%h expected t=1 m=1 tgt=240", out_branch_taken, out_mispredict, out_target);
            end
         end
         if (i == 1) begin
            checks++;
            if (out_branch_taken !== 1'b0 || out_mispredict !== 1'b0) begin
               errors++; $display("FAIL bltu_unsigned: got t=%b m=%b expected t=0 m=0", out_branch_taken, out_mispredict);
            end
         end
      end
      in_valid = 1'b0;
      cycle();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL branch_drain: got %b expected 0", out_valid); end
   endtask

   task automatic test_jumps_decode();
      for (int i = 0; i < 10; i++) begin
         case (i)
            0: drive(7'b1100111, OP_I, 3'd0, 32'h300, 32'h1001, 32'd0, 32'd4, 1'b1);
            1: drive(7'b1100111, OP_I, 3'd0, 32'h304, 32'h2000, 32'd0, 32'hFFFF_FFFF, 1'b0);
            2: drive(7'b1101111, OP_J, 3'd0, 32'hFFFF_FFF0, 32'd0, 32'd0, 32'h20, 1'b0);
            3: drive(7'b1101111, OP_J, 3'd0, 32'h308, 32'd0, 32'd0, 32'h100, 1'b1);
            4: drive(7'b0110011, OP_R, 3'd0, 32'h30C, 32'd3, 32'd4, 32'd0, 1'b1);
            5: drive(7'b0010011, OP_I, 3'd0, 32'h310, 32'd3, 32'd4, 32'd7, 1'b1);
            6: drive(7'b0000011, OP_I, 3'd2, 32'h314, 32'd3, 32'd4, 32'd8, 1'b0);
            7: drive(7'b0000111, OP_I, 3'd2, 32'h318, 32'd3, 32'd4, 32'd8, 1'b0);
            8: drive(7'b0100011, OP_S, 3'd2, 32'h31C, 32'd3, 32'd4, 32'd8, 1'b1);
            default: drive(7'b0010111, OP_U, 3'd0, 32'h320, 32'd0, 32'd0, 32'h1000, 1'b0);
         endcase
         cycle();
         checks++;
         if (out_valid !== 1'b1 || sb.size() == 0 || obs !== sb[0]) begin
            errors++; $display("FAIL decode[%0d]: got v=%b %h expected %h", i, out_valid, obs, (sb.size() > 0) ? sb[0] : '0);
         end
         if (i == 0) begin
            checks++;
            if (out_target !== 32'h1004 || out_ctrl.is_jump !== 1'b1 || out_ctrl.reg_write !== 1'b1 || out_mispredict !== 1'b0) begin
               errors++; $display("FAIL jalr_basic: got tgt=%h j=%b rw=%b m=%b expected 1004 1 1 0", out_target, out_ctrl.is_jump, out_ctrl.reg_write, out_mispredict);
            end
         end
      end
      drive(7'b0110111, OP_U, 3'd0, 32'h324, 32'd0, 32'd0, 32'h5000, 1'b1);
      cycle();
      checks++;
      if (out_ctrl !== 7'b0011000 || out_mispredict !== 1'b0) begin
         errors++; $display("FAIL lui_ctrl: got %b m=%b expected 0011000 m=0", out_ctrl, out_mispredict);
      end
      in_valid = 1'b0;
      cycle();
   endtask

   task automatic test_backpressure();
      out_ready = 1'b1;
      drive(7'b0110011, OP_R, 3'd0, 32'h400, 32'd1, 32'd2, 32'd0, 1'b0);
      cycle();
      out_ready = 1'b0;
      drive(7'b1101111, OP_J, 3'd0, 32'h404, 32'd0, 32'd0, 32'h80, 1'b0);
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (in_ready !== (!model_ov || out_ready)) begin
            errors++; $display("FAIL hold_in_ready[%0d]: got %b expected %b", i, in_ready, !model_ov || out_ready);
         end
         cycle();
         checks++;
         if (out_valid !== 1'b1 || sb.size() == 0 || obs !== sb[0]) begin
            errors++; $display("FAIL hold_stable[%0d]: got v=%b %h expected %h", i, out_valid, obs, (sb.size() > 0) ? sb[0] : '0);
         end
      end
      out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b expected 1", in_ready); end
      cycle();
      checks++;
      if (out_valid !== 1'b1 || sb.size() != 1 || obs !== sb[0] || out_ctrl.is_jump !== 1'b1) begin
         errors++; $display("FAIL release_next: got v=%b %h expected %h", out_valid, obs, (sb.size() > 0) ? sb[0] : '0);
      end
      in_valid = 1'b0;
      cycle();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL release_drain: got %b expected 0", out_valid); end
   endtask

   task automatic test_bht();
      logic exp_lt;
      lookup_pc = 32'h40;
      for (int i = 0; i < 6; i++) begin
         case (i)
            0, 1, 2: drive(7'b1100011, OP_B, 3'd0, 32'h40, 32'd9, 32'd9, 32'h10, 1'b1);
            3, 4:    drive(7'b1100011, OP_B, 3'd0, 32'h40, 32'd9, 32'd8, 32'h10, 1'b1);
            default: drive(7'b1101111, OP_J, 3'd0, 32'h40, 32'd0, 32'd0, 32'h10, 1'b0);
         endcase
         #1;
         exp_lt = lookup_m(32'h40);
         checks++;
         if (lookup_taken !== exp_lt) begin
            errors++; $display("FAIL bht_pre[%0d]: got %b expected %b", i, lookup_taken, exp_lt);
         end
         cycle();
         exp_lt = lookup_m(32'h40);
         checks++;
         if (lookup_taken !== exp_lt || out_valid !== 1'b1 || sb.size() == 0 || obs !== sb[0]) begin
            errors++; $display("FAIL bht_post[%0d]: got lt=%b %h expected lt=%b %h", i, lookup_taken, obs, exp_lt, (sb.size() > 0) ? sb[0] : '0);
         end
      end
      in_valid = 1'b0;
      cycle();
   endtask

   task automatic test_flush();
      logic exp_lt;
      lookup_pc = 32'h48;
      drive(7'b1100011, OP_B, 3'd0, 32'h48, 32'd1, 32'd1, 32'h10, 1'b0);
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      in_valid = 1'b0;
      exp_lt = lookup_m(32'h48);
      checks++;
      if (out_valid !== 1'b0 || lookup_taken !== exp_lt) begin
         errors++; $display("FAIL flush_accept: got v=%b lt=%b expected v=0 lt=%b", out_valid, lookup_taken, exp_lt);
      end
      drive(7'b1100011, OP_B, 3'd0, 32'h48, 32'd1, 32'd2, 32'h10, 1'b0);
      cycle();
      in_valid = 1'b0;
      exp_lt = lookup_m(32'h48);
      checks++;
      if (out_valid !== 1'b1 || lookup_taken !== exp_lt || sb.size() == 0 || obs !== sb[0]) begin
         errors++; $display("FAIL flush_after: got v=%b lt=%b expected v=1 lt=%b", out_valid, lookup_taken, exp_lt);
      end
      out_ready = 1'b0;
      drive(7'b0110011, OP_R, 3'd0, 32'h500, 32'd1, 32'd2, 32'd0, 1'b0);
      cycle();
      in_valid = 1'b0;
      cycle();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_held_pre: got %b expected 1", out_valid); end
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_held: got %b expected 0", out_valid); end
      out_ready = 1'b1;
   endtask

   task automatic test_reset_midhandshake();
      out_ready = 1'b0;
      drive(7'b0000011, OP_I, 3'd2, 32'h600, 32'd4, 32'd0, 32'd4, 1'b0);
      cycle();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre: got %b expected 1", out_valid); end
      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
      checks++;
      if (out_valid !== 1'b0 || obs !== '0) begin
         errors++; $display("FAIL mid_reset: got v=%b %h expected v=0 0", out_valid, obs);
      end
      lookup_pc = 32'h40;
      #1;
      checks++; if (lookup_taken !== 1'b0) begin errors++; $display("FAIL mid_reset_bht: got %b expected 0", lookup_taken); end
      out_ready = 1'b1;
      cycle();
   endtask

   initial begin
      for (int i = 0; i < BHT_DEPTH; i++) bht_m[i] = 2'b01;
      test_reset();
      test_branch_compare();
      test_jumps_decode();
      test_backpressure();
      test_bht();
      test_flush();
      test_reset_midhandshake();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no completion expected finish");
      $fatal(1, "timeout");
   end

endmodule
